offset_finder_unit: RTL and testbench

OFFSET_FINDER_UNIT -- requirements
Module: offset_finder_unit

---
 rtl/offset_finder_pkg.sv | 14 +
 rtl/offset_finder_unit_lfsr_step.sv | 12 +
 rtl/offset_finder_unit.sv | 112 +++++++++++
 tb/tb_offset_finder_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/offset_finder_pkg.sv
// Shared constants and state encoding for the LFSR offset finder.
package offset_finder_pkg;

  localparam int                LFSR_W    = 17;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h00001;
  localparam logic [LFSR_W-1:0] MAX_STEPS = 17'h1FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/offset_finder_unit_lfsr_step.sv
// One Fibonacci-style LFSR advance: shift left, feedback = parity of tapped bits.
module lfsr_step
  import offset_finder_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  input  logic [LFSR_W-1:0] polynomial,
  output logic [LFSR_W-1:0] next
);

  assign next = {state[LFSR_W-2:0], ^(state & polynomial)};

endmodule

// File: rtl/offset_finder_unit.sv
// Steps an LFSR from the seed and reports how many steps it takes to reach data.
// Optional feature: OFFSET_EARLY_ABORT_EN stops the search when the LFSR cycles back to the seed.
module offset_finder_unit
  import offset_finder_pkg::*;
#(
  parameter logic [LFSR_W-1:0] MAX_CNT = MAX_STEPS
) (
  input  logic              clk_72MHz,
  input  logic              reset,
  input  logic [LFSR_W-1:0] polynomial,
  input  logic [LFSR_W-1:0] data,
  input  logic              enable,
  output logic [LFSR_W-1:0] offset,
  output logic              ready
);

`ifdef OFFSET_EARLY_ABORT_EN
  localparam logic EARLY_ABORT = 1'b1;
`else
  localparam logic EARLY_ABORT = 1'b0;
`endif

  state_t            fsm;
  logic [LFSR_W-1:0] lfsr_p0;
  logic [LFSR_W-1:0] count_p0;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [LFSR_W-1:0] count_p1;
  logic              vld_p1;
  logic              match_p1;
  logic              seed_p1;
  logic              no_search;

  lfsr_step u_lfsr_step (
    .state      (lfsr_p0),
    .polynomial (polynomial),
    .next       (lfsr_nxt)
  );

  assign no_search = (polynomial == '0) || (data == '0);

  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      fsm      <= IDLE;
      lfsr_p0  <= LFSR_SEED;
      count_p0 <= '0;
      count_p1 <= '0;
      vld_p1   <= 1'b0;
      match_p1 <= 1'b0;
      seed_p1  <= 1'b0;
      offset   <= '0;
      ready    <= 1'b0;
    end else if (!enable) begin
      fsm      <= IDLE;
      lfsr_p0  <= LFSR_SEED;
      count_p0 <= '0;
      count_p1 <= '0;
      vld_p1   <= 1'b0;
      match_p1 <= 1'b0;
      seed_p1  <= 1'b0;
      offset   <= '0;
      ready    <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          fsm      <= SEARCH;
          lfsr_p0  <= LFSR_SEED;
          count_p0 <= '0;
          count_p1 <= '0;
          vld_p1   <= 1'b0;
          match_p1 <= 1'b0;
          seed_p1  <= 1'b0;
          offset   <= '0;
          ready    <= 1'b0;
        end
        SEARCH: begin
          if (no_search) begin
            fsm    <= DONE;
            offset <= '0;
            ready  <= 1'b1;
          end else if (vld_p1 && match_p1) begin
            fsm    <= DONE;
            offset <= count_p1;
            ready  <= 1'b1;
          end else if (vld_p1 && ((count_p1 == MAX_CNT) || seed_p1)) begin
            fsm    <= DONE;
            offset <= '0;
            ready  <= 1'b1;
          end else begin
            // p0 -> p1: step the LFSR while comparing the value it already holds
            if (count_p0 != MAX_CNT) begin
              lfsr_p0  <= lfsr_nxt;
              count_p0 <= count_p0 + 1'b1;
            end
            vld_p1   <= (count_p0 != '0);
            match_p1 <= (lfsr_p0 == data);
            seed_p1  <= EARLY_ABORT && (lfsr_p0 == LFSR_SEED);
            count_p1 <= count_p0;
          end
        end
        DONE: begin
          fsm <= DONE;
        end
        default: begin
          fsm    <= IDLE;
          offset <= '0;
          ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_offset_finder_unit.sv
// Self-checking bench for offset_finder_unit: directed table, corner sequences, random vs model.
module tb_offset_finder_unit;

  localparam int          TB_MAX = 300;
  localparam logic [16:0] SEED_V = 17'h00001;
`ifdef OFFSET_EARLY_ABORT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [16:0] poly;
    logic [16:0] dat;
    logic [16:0] exp_off;
    int          exp_lat;
  } vec_t;

  logic        clk_72MHz = 1'b0;
  logic        reset;
  logic        enable;
  logic [16:0] polynomial;
  logic [16:0] data;
  logic [16:0] offset;
  logic        ready;

  int checks = 0;
  int errors = 0;

  always #5 clk_72MHz = ~clk_72MHz;

  offset_finder_unit #(.MAX_CNT(17'(TB_MAX))) dut (
    .clk_72MHz  (clk_72MHz),
    .reset      (reset),
    .polynomial (polynomial),
    .data       (data),
    .enable     (enable),
    .offset     (offset),
    .ready      (ready)
  );

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: shift the word left one place, new low bit is the parity of the tapped bits.
  function automatic logic [16:0] advance(input logic [16:0] s, input logic [16:0] p);
    logic [16:0] shifted;
    int          taps;
    shifted = 17'((s * 2) % 131072);
    taps    = $countones(s & p);
    return shifted + 17'(taps % 2);
  endfunction

  function automatic logic [16:0] state_after(input logic [16:0] p, input int steps);
    logic [16:0] s;
    s = SEED_V;
    for (int i = 0; i < steps; i++) s = advance(s, p);
    return s;
  endfunction

  // Expected offset and ready latency (edges after the edge that samples enable).
  task automatic model(input logic [16:0] p, input logic [16:0] d,
                       output logic [16:0] off, output int lat);
    logic [16:0] s;
    off = 17'd0;
    lat = TB_MAX + 2;
    if (p == 17'd0 || d == 17'd0) begin
      lat = 1;
      return;
    end
    s = SEED_V;
    for (int k = 1; k <= TB_MAX; k++) begin
      s = advance(s, p);
      if (s == d) begin
        off = 17'(k);
        lat = k + 2;
        return;
      end
      if (EARLY && s == SEED_V) begin
        lat = k + 2;
        return;
      end
    end
  endtask

  task automatic run_search(input string tag, input logic [16:0] p, input logic [16:0] d,
                            input logic [16:0] eoff, input int elat);
    @(posedge clk_72MHz); #1;
    polynomial = p;
    data       = d;
    enable     = 1'b1;
    check({tag, " idle_ready"}, 17'(ready), 17'd0);
    @(posedge clk_72MHz);
    for (int n = 1; n < elat; n++) begin
      @(posedge clk_72MHz); #1;
      check({tag, " early_ready"}, 17'(ready), 17'd0);
    end
    @(posedge clk_72MHz); #1;
    check({tag, " ready"}, 17'(ready), 17'd1);
    check({tag, " offset"}, offset, eoff);
    repeat (3) @(posedge clk_72MHz);
    #1;
    check({tag, " hold_ready"}, 17'(ready), 17'd1);
    check({tag, " hold_offset"}, offset, eoff);
    enable = 1'b0;
    @(posedge clk_72MHz); #1;
    check({tag, " drop_ready"}, 17'(ready), 17'd0);
    check({tag, " drop_offset"}, offset, 17'd0);
  endtask

  vec_t        vecs[6];
  logic [16:0] eoff;
  int          elat;
  logic [16:0] absent_d;

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    polynomial = 17'd0;
    data       = 17'd0;

    vecs[0] = '{17'h1D258, 17'h00002, 17'd1, 3};
    vecs[1] = '{17'h1D258, 17'h00011, 17'd4, 6};
    vecs[2] = '{17'h00000, 17'h00011, 17'd0, 1};
    vecs[3] = '{17'h1D258, 17'h00000, 17'd0, 1};
    vecs[4].poly = 17'h1D258;
    vecs[4].dat  = state_after(17'h1D258, TB_MAX);
    model(vecs[4].poly, vecs[4].dat, vecs[4].exp_off, vecs[4].exp_lat);
    vecs[5].poly = 17'h1D258;
    vecs[5].dat  = state_after(17'h1D258, TB_MAX + 1);
    model(vecs[5].poly, vecs[5].dat, vecs[5].exp_off, vecs[5].exp_lat);
    absent_d = vecs[5].dat;

    #12;
    check("reset_ready", 17'(ready), 17'd0);
    check("reset_offset", offset, 17'd0);
    @(posedge clk_72MHz); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk_72MHz);
    #1;
    check("post_reset_idle", 17'(ready), 17'd0);

    for (int i = 0; i < 6; i++)
      run_search($sformatf("vec%0d", i), vecs[i].poly, vecs[i].dat, vecs[i].exp_off, vecs[i].exp_lat);

    // Abort after 10 search cycles, then re-enable.
    @(posedge clk_72MHz); #1;
    polynomial = 17'h1D258;
    data       = absent_d;
    enable     = 1'b1;
    @(posedge clk_72MHz);
    for (int n = 0; n < 10; n++) begin
      @(posedge clk_72MHz); #1;
      check("abort_search_ready", 17'(ready), 17'd0);
    end
    enable = 1'b0;
    @(posedge clk_72MHz); #1;
    check("abort_ready", 17'(ready), 17'd0);
    check("abort_offset", offset, 17'd0);
    repeat (3) @(posedge clk_72MHz);
    #1;
    check("abort_stays_idle", 17'(ready), 17'd0);
    run_search("reenable", 17'h1D258, 17'h00002, 17'd1, 3);

    // Asynchronous reset mid-search.
    @(posedge clk_72MHz); #1;
    polynomial = 17'h1D258;
    data       = absent_d;
    enable     = 1'b1;
    repeat (6) @(posedge clk_72MHz);
    #3;
    reset = 1'b1;
    #1;
    check("rst_search_ready", 17'(ready), 17'd0);
    check("rst_search_offset", offset, 17'd0);
    enable = 1'b0;
    @(posedge clk_72MHz); #1;
    reset = 1'b0;

    // Asynchronous reset while a result is held.
    polynomial = 17'h1D258;
    data       = 17'h00011;
    enable     = 1'b1;
    repeat (7) @(posedge clk_72MHz);
    #1;
    check("pre_rst_ready", 17'(ready), 17'd1);
    check("pre_rst_offset", offset, 17'd4);
    #2;
    reset = 1'b1;
    #1;
    check("rst_done_ready", 17'(ready), 17'd0);
    check("rst_done_offset", offset, 17'd0);
    enable = 1'b0;
    @(posedge clk_72MHz); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk_72MHz);
    #1;
    check("rst_release_idle", 17'(ready), 17'd0);

    // Randomized polynomials and targets against the model.
    for (int i = 0; i < 24; i++) begin
      logic [16:0] p;
      logic [16:0] d;
      p = 17'($urandom);
      if (i % 8 == 0) p = 17'd0;
      d = state_after(p, $urandom_range(1, TB_MAX + 20));
      if (i % 8 == 3) d = 17'($urandom);
      if (i % 8 == 5) d = 17'd0;
      model(p, d, eoff, elat);
      run_search($sformatf("rand%0d", i), p, d, eoff, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
